// File: rtl/roce_stack_addr_xlat_arbiter_pkg.sv
// Shared types for the address-translation arbiter: requester owner, FSM state, bus widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package roce_stack_addr_xlat_arbiter_pkg;

    localparam int VADDR_BITS     = 64;
    localparam int XLAT_RESP_BITS = 116;

    // Which request handler owns the lookup currently on the shared port
    typedef enum logic {
        OWN_RD = 1'b0,
        OWN_WR = 1'b1
    } owner_t;

    // Arbiter FSM: IDLE picks a requester, ISSUE drives the shared request, WAIT routes the response
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Timeout counter is at least 16 bits, wider only if the limit needs it
    function automatic int tmo_width(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        return (w > 16) ? w : 16;
    endfunction

endpackage

// File: rtl/roce_stack_addr_xlat_arbiter.sv
// Round-robin arbiter sharing one translation port between read and write request handlers.
// Latency: request accepted at cycle N appears on the shared port at N+1; response routed combinationally.
// Backpressure: one lookup outstanding; upstream readys low until the response handshake completes.
module roce_stack_addr_xlat_arbiter
    import roce_stack_addr_xlat_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      axis_aclk_i,
    input  logic                      aresetn_i,

    input  logic                      rd_req_valid_i,
    output logic                      rd_req_ready_o,
    input  logic [VADDR_BITS-1:0]     rd_req_vaddr_i,
    output logic                      rd_resp_valid_o,
    input  logic                      rd_resp_ready_i,
    output logic [XLAT_RESP_BITS-1:0] rd_resp_data_o,

    input  logic                      wr_req_valid_i,
    output logic                      wr_req_ready_o,
    input  logic [VADDR_BITS-1:0]     wr_req_vaddr_i,
    output logic                      wr_resp_valid_o,
    input  logic                      wr_resp_ready_i,
    output logic [XLAT_RESP_BITS-1:0] wr_resp_data_o,

    output logic                      req_addr_valid_o,
    input  logic                      req_addr_ready_i,
    output logic [VADDR_BITS-1:0]     req_addr_vaddr_o,
    input  logic                      resp_addr_valid_i,
    output logic                      resp_addr_ready_o,
    input  logic [XLAT_RESP_BITS-1:0] resp_addr_data_i,

    output logic                      busy_o,
    output logic                      timeout_err_o,
    output logic [31:0]               rd_grant_cnt_o,
    output logic [31:0]               wr_grant_cnt_o
);

    localparam int               TMO_W     = tmo_width(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_MAX   = '1;
    localparam bit               TMO_EN    = (TIMEOUT_CYCLES != 0);

    state_t                  state_q;
    state_t                  state_d;
    owner_t                  owner_q;
    owner_t                  last_grant_q;
    logic [VADDR_BITS-1:0]   vaddr_q;
    logic [31:0]             rd_cnt_q;
    logic [31:0]             wr_cnt_q;
    logic [TMO_W-1:0]        tmo_cnt_q;
    logic [TMO_W-1:0]        tmo_cnt_nxt;
    logic                    tmo_err_q;

    logic                    grant_rd;
    logic                    grant_wr;
    logic                    up_hs;
    logic                    iss_hs;
    logic                    owner_rdy;
    logic                    resp_hs;

    // Arbitration in IDLE: a lone requester wins; on a tie the one not granted last wins
    always_comb begin
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        if (state_q == ST_IDLE) begin
            if (rd_req_valid_i && (!wr_req_valid_i || last_grant_q == OWN_WR)) begin
                grant_rd = 1'b1;
            end else if (wr_req_valid_i) begin
                grant_wr = 1'b1;
            end
        end
    end

    // Handshake qualifiers shared by the FSM and datapath
    always_comb begin
        up_hs       = grant_rd | grant_wr;
        iss_hs      = (state_q == ST_ISSUE) && req_addr_ready_i;
        owner_rdy   = (owner_q == OWN_RD) ? rd_resp_ready_i : wr_resp_ready_i;
        resp_hs     = (state_q == ST_WAIT) && resp_addr_valid_i && owner_rdy;
        tmo_cnt_nxt = (tmo_cnt_q == TMO_MAX) ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);
    end

    // FSM state register
    always_ff @(posedge axis_aclk_i) begin
        if (!aresetn_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (up_hs)   state_d = ST_ISSUE;
            ST_ISSUE: if (iss_hs)  state_d = ST_WAIT;
            ST_WAIT:  if (resp_hs) state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: upstream readys only to the granted side, response steered to the owner
    always_comb begin
        rd_req_ready_o    = grant_rd;
        wr_req_ready_o    = grant_wr;
        req_addr_valid_o  = 1'b0;
        req_addr_vaddr_o  = '0;
        resp_addr_ready_o = 1'b0;
        rd_resp_valid_o   = 1'b0;
        rd_resp_data_o    = '0;
        wr_resp_valid_o   = 1'b0;
        wr_resp_data_o    = '0;
        busy_o            = (state_q != ST_IDLE);
        case (state_q)
            ST_ISSUE: begin
                req_addr_valid_o = 1'b1;
                req_addr_vaddr_o = vaddr_q;
            end
            ST_WAIT: begin
                resp_addr_ready_o = owner_rdy;
                if (owner_q == OWN_RD) begin
                    rd_resp_valid_o = resp_addr_valid_i;
                    rd_resp_data_o  = resp_addr_valid_i ? resp_addr_data_i : '0;
                end else begin
                    wr_resp_valid_o = resp_addr_valid_i;
                    wr_resp_data_o  = resp_addr_valid_i ? resp_addr_data_i : '0;
                end
            end
            default: ;
        endcase
    end

    // Capture the granted request and bump its grant counter
    always_ff @(posedge axis_aclk_i) begin
        if (!aresetn_i) begin
            owner_q      <= OWN_RD;
            last_grant_q <= OWN_WR;
            vaddr_q      <= '0;
            rd_cnt_q     <= '0;
            wr_cnt_q     <= '0;
        end else if (grant_rd) begin
            owner_q      <= OWN_RD;
            last_grant_q <= OWN_RD;
            vaddr_q      <= rd_req_vaddr_i;
            rd_cnt_q     <= rd_cnt_q + 32'd1;
        end else if (grant_wr) begin
            owner_q      <= OWN_WR;
            last_grant_q <= OWN_WR;
            vaddr_q      <= wr_req_vaddr_i;
            wr_cnt_q     <= wr_cnt_q + 32'd1;
        end
    end

    // WAIT watchdog: counts stalled WAIT cycles and latches a sticky diagnostic flag
    always_ff @(posedge axis_aclk_i) begin
        if (!aresetn_i) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            if (iss_hs) begin
                tmo_cnt_q <= '0;
            end else if (state_q == ST_WAIT && !resp_hs) begin
                tmo_cnt_q <= tmo_cnt_nxt;
            end
            if (TMO_EN && state_q == ST_WAIT && !resp_hs && tmo_cnt_nxt >= TMO_LIMIT) begin
                tmo_err_q <= 1'b1;
            end
        end
    end

    assign timeout_err_o  = tmo_err_q;
    assign rd_grant_cnt_o = rd_cnt_q;
    assign wr_grant_cnt_o = wr_cnt_q;

endmodule

// File: doc/roce_stack_addr_xlat_arbiter.md
ROCE_STACK_ADDR_XLAT_ARBITER -- requirements
Module: roce_stack_addr_xlat_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 4096, WAIT-state cycles before timeout flag; 0 disables timeout.
REQ-002 axis_aclk_i  in  1  sole clock; all logic rising-edge.
REQ-003 aresetn_i  in  1  reset, synchronous, active-low.
REQ-004 rd_req_valid_i / rd_req_ready_o / rd_req_vaddr_i  in/out/in  1/1/64  read-handler lookup request.
REQ-005 rd_resp_valid_o / rd_resp_ready_i / rd_resp_data_o  out/in/out  1/1/116  read-handler lookup response.
REQ-006 wr_req_valid_i / wr_req_ready_o / wr_req_vaddr_i  in/out/in  1/1/64  write-handler lookup request.
REQ-007 wr_resp_valid_o / wr_resp_ready_i / wr_resp_data_o  out/in/out  1/1/116  write-handler lookup response.
REQ-008 req_addr_valid_o / req_addr_ready_i / req_addr_vaddr_o  out/in/out  1/1/64  shared translation request port.
REQ-009 resp_addr_valid_i / resp_addr_ready_o / resp_addr_data_i  in/out/in  1/1/116  shared translation response port.
REQ-010 busy_o  out  1  high whenever state is not IDLE.
REQ-011 timeout_err_o  out  1  sticky; set on WAIT timeout.
REQ-012 rd_grant_cnt_o / wr_grant_cnt_o  out  32 each  accepted-request counters, wrap at 2^32.

Function
REQ-013 FSM states IDLE, ISSUE, WAIT; exactly one lookup outstanding on the shared port at any time.
REQ-014 IDLE: grant the single valid requester; if both valid, grant the one not granted last (round-robin); last_grant resets to WR, so READ wins the first tie.
REQ-015 IDLE: ready asserted only to the granted requester, same cycle as its valid (combinational); other ready low; ISSUE/WAIT: both upstream readys low.
REQ-016 On upstream handshake: register vaddr and owner (RD/WR), update last_grant, increment that grant counter, go to ISSUE.
REQ-017 ISSUE: req_addr_valid_o=1 with registered vaddr, held stable until req_addr_ready_i; then WAIT. Upstream accept at cycle N yields req_addr_valid_o at N+1.
REQ-018 WAIT: resp routed combinationally to owner: owner_resp_valid_o=resp_addr_valid_i, owner_resp_data_o=resp_addr_data_i, resp_addr_ready_o=owner_resp_ready_i; non-owner resp_valid_o=0.
REQ-019 WAIT: on response handshake go to IDLE; new grant possible the next cycle (2-cycle minimum per lookup, excluding downstream stalls).
REQ-020 resp_addr_ready_o=0 in IDLE and ISSUE; stray responses are back-pressured, never dropped.
REQ-021 resp data outputs are zero whenever the corresponding valid is low.
REQ-022 Timeout: 16-bit (min) counter clears on WAIT entry, increments each WAIT cycle without response handshake, saturates; reaching TIMEOUT_CYCLES sets timeout_err_o; FSM keeps waiting (diagnostic only).
REQ-023 timeout_err_o clears only on reset.

Reset
REQ-024 While aresetn_i low at a clock edge: state IDLE, last_grant WR, counters 0, timeout_err_o 0, captured vaddr/owner 0.
REQ-025 Reset-value outputs: all valid/ready outputs 0, busy_o 0, data outputs 0, grant counters 0.
REQ-026 Reset mid-ISSUE/WAIT abandons the lookup with no response to the owner; upstream handlers are reset by the same signal.

Structure
REQ-027 Shared package (lynxTypes): owner enum (RD, WR), FSM state enum, VADDR_BITS=64, XLAT_RESP_BITS=116.
REQ-028 Single flat module; no sub-module; instantiated between the two request handlers and the translation unit inside the axis-to-aximm wrapper.

Verification
REQ-029 Single read: rd_req vaddr 0x1000, ready_i=1 -> req_addr_vaddr_o=0x1000 one cycle after accept; resp data 0xABC on rd_resp only; rd_grant_cnt_o=1.
REQ-030 Simultaneous rd/wr valid after reset -> RD served first, WR second; repeat tie -> RD again (alternation RD,WR,RD,WR); counters equal.
REQ-031 req_addr_ready_i low 5 cycles in ISSUE -> valid/vaddr stable all 5 cycles; no upstream ready asserted.
REQ-032 wr owner, wr_resp_ready_i low 3 cycles with resp valid -> resp_addr_ready_o low 3 cycles, data held; rd_resp_valid_o stays 0.
REQ-033 TIMEOUT_CYCLES=8, no response -> timeout_err_o rises after 8 WAIT cycles, stays high; late response still delivered; reset clears flag.
REQ-034 Reset asserted in WAIT -> next cycle IDLE, busy_o=0, all outputs at reset values; subsequent request served normally.
